// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: T-state counter, opcode decode, and the control word.
// Control word is combinational from the current step; the step advances once per enabled edge.
// clk_en low freezes step and halt; HLT freezes the step at T2 until reset. Macro: SAP1_COND_JUMP_EN.
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    clk_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_flag_zero,
  input  logic                    i_flag_carry,
  output logic [2:0]              o_tstate,
  output logic                    o_halt,
  output logic                    o_pc_out,
  output logic                    o_pc_inc,
  output logic                    o_pc_load,
  output logic                    o_mar_load,
  output logic                    o_ram_out,
  output logic                    o_ram_load,
  output logic                    o_ir_load,
  output logic                    o_ir_out,
  output logic                    o_a_load,
  output logic                    o_a_out,
  output logic                    o_b_load,
  output logic                    o_alu_out,
  output logic                    o_alu_sub,
  output logic                    o_out_load
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'b0000);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'b0001);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'b0010);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'b0011);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'b0100);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'b0101);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'b0110);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'b0111);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'b1110);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'b1111);

  step_t step_q, step_d;
  logic  halt_q, halt_d;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else if (clk_en) begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

`ifndef SAP1_COND_JUMP_EN
  // Flags only matter to conditional jumps; keep them visibly consumed.
  logic unused_flags;
  assign unused_flags = i_flag_zero ^ i_flag_carry;
`endif

  always_comb begin
    step_d     = T0;
    halt_d     = halt_q;
    o_pc_out   = 1'b0;
    o_pc_inc   = 1'b0;
    o_pc_load  = 1'b0;
    o_mar_load = 1'b0;
    o_ram_out  = 1'b0;
    o_ram_load = 1'b0;
    o_ir_load  = 1'b0;
    o_ir_out   = 1'b0;
    o_a_load   = 1'b0;
    o_a_out    = 1'b0;
    o_b_load   = 1'b0;
    o_alu_out  = 1'b0;
    o_alu_sub  = 1'b0;
    o_out_load = 1'b0;

    if (halt_q) begin
      step_d = step_q;
    end else begin
      case (step_q)
        T0: begin
          o_pc_out   = 1'b1;
          o_mar_load = 1'b1;
          step_d     = T1;
        end
        T1: begin
          o_ram_out = 1'b1;
          o_ir_load = 1'b1;
          o_pc_inc  = 1'b1;
          step_d    = T2;
        end
        T2: begin
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              o_ir_out   = 1'b1;
              o_mar_load = 1'b1;
              step_d     = T3;
            end
            OP_JMP: begin
              o_ir_out  = 1'b1;
              o_pc_load = 1'b1;
            end
`ifdef SAP1_COND_JUMP_EN
            OP_JZ: begin
              o_ir_out  = i_flag_zero;
              o_pc_load = i_flag_zero;
            end
            OP_JC: begin
              o_ir_out  = i_flag_carry;
              o_pc_load = i_flag_carry;
            end
`endif
            OP_LDI: begin
              o_ir_out = 1'b1;
              o_a_load = 1'b1;
            end
            OP_OUT: begin
              o_a_out    = 1'b1;
              o_out_load = 1'b1;
            end
            OP_HLT: begin
              halt_d = 1'b1;
              step_d = T2;
            end
            default: ;
          endcase
        end
        T3: begin
          case (i_opcode)
            OP_LDA: begin
              o_ram_out = 1'b1;
              o_a_load  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              o_ram_out = 1'b1;
              o_b_load  = 1'b1;
              o_alu_sub = (i_opcode == OP_SUB);
              step_d    = T4;
            end
            OP_STA: begin
              o_a_out    = 1'b1;
              o_ram_load = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
            o_alu_out = 1'b1;
            o_a_load  = 1'b1;
            o_alu_sub = (i_opcode == OP_SUB);
          end
        end
        default: step_d = T0;
      endcase
    end
  end

  assign o_tstate = step_q;
  assign o_halt   = halt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: driver queues expected step/halt/control word, monitor compares.
module tb_control_sequencer;

  localparam logic [13:0] PC_OUT   = 14'h2000;
  localparam logic [13:0] PC_INC   = 14'h1000;
  localparam logic [13:0] PC_LOAD  = 14'h0800;
  localparam logic [13:0] MAR_LOAD = 14'h0400;
  localparam logic [13:0] RAM_OUT  = 14'h0200;
  localparam logic [13:0] RAM_LOAD = 14'h0100;
  localparam logic [13:0] IR_LOAD  = 14'h0080;
  localparam logic [13:0] IR_OUT   = 14'h0040;
  localparam logic [13:0] A_LOAD   = 14'h0020;
  localparam logic [13:0] A_OUT    = 14'h0010;
  localparam logic [13:0] B_LOAD   = 14'h0008;
  localparam logic [13:0] ALU_OUT  = 14'h0004;
  localparam logic [13:0] ALU_SUB  = 14'h0002;
  localparam logic [13:0] OUT_LOAD = 14'h0001;

  localparam logic [13:0] W_F0 = PC_OUT | MAR_LOAD;
  localparam logic [13:0] W_F1 = RAM_OUT | IR_LOAD | PC_INC;

`ifdef SAP1_COND_JUMP_EN
  localparam logic [13:0] W_JTAKEN = IR_OUT | PC_LOAD;
`else
  localparam logic [13:0] W_JTAKEN = 14'h0000;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic [3:0] i_opcode = 4'h0;
  logic       i_flag_zero = 1'b0;
  logic       i_flag_carry = 1'b0;
  logic [2:0] o_tstate;
  logic       o_halt;
  logic o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_load, o_ir_load;
  logic o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_out, o_alu_sub, o_out_load;

  control_sequencer #(.OPCODE_WIDTH(4)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .clk_en(clk_en), .i_opcode(i_opcode),
    .i_flag_zero(i_flag_zero), .i_flag_carry(i_flag_carry),
    .o_tstate(o_tstate), .o_halt(o_halt),
    .o_pc_out(o_pc_out), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load),
    .o_mar_load(o_mar_load), .o_ram_out(o_ram_out), .o_ram_load(o_ram_load),
    .o_ir_load(o_ir_load), .o_ir_out(o_ir_out),
    .o_a_load(o_a_load), .o_a_out(o_a_out), .o_b_load(o_b_load),
    .o_alu_out(o_alu_out), .o_alu_sub(o_alu_sub), .o_out_load(o_out_load)
  );

  always #5 clk = ~clk;

  logic [13:0] act_word;
  assign act_word = {o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_load,
                     o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_out,
                     o_alu_sub, o_out_load};

  typedef struct packed {
    logic [2:0]  tstate;
    logic        halt;
    logic [13:0] word;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  // Monitor: one queued expectation is consumed at each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (o_tstate !== e.tstate || o_halt !== e.halt || act_word !== e.word) begin
        failures++;
        $display("FAIL %s: got t=%0d halt=%0b word=%04h, want t=%0d halt=%0b word=%04h",
                 n, o_tstate, o_halt, act_word, e.tstate, e.halt, e.word);
      end
    end
  end

  task automatic cyc(input logic rst_n, input logic en);
    i_rst_n = rst_n;
    clk_en  = en;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string n, input logic [2:0] t, input logic h,
                            input logic [13:0] w);
    exp_t e;
    e.tstate = t;
    e.halt   = h;
    e.word   = w;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Runs one instruction from T0 (already checked) back to T0.
  task automatic run_instr(input string n, input logic [3:0] op, input logic z, input logic c,
                           input int len, input logic [13:0] w2, input logic [13:0] w3,
                           input logic [13:0] w4);
    i_opcode     = op;
    i_flag_zero  = z;
    i_flag_carry = c;
    cyc(1'b1, 1'b1); expect_now({n, "_t1"}, 3'd1, 1'b0, W_F1);
    cyc(1'b1, 1'b1); expect_now({n, "_t2"}, 3'd2, 1'b0, w2);
    if (len > 3) begin
      cyc(1'b1, 1'b1); expect_now({n, "_t3"}, 3'd3, 1'b0, w3);
    end
    if (len > 4) begin
      cyc(1'b1, 1'b1); expect_now({n, "_t4"}, 3'd4, 1'b0, w4);
    end
    cyc(1'b1, 1'b1); expect_now({n, "_t0"}, 3'd0, 1'b0, W_F0);
  endtask

  initial begin
    // Reset must take effect even with clk_en low.
    cyc(1'b0, 1'b0); expect_now("reset_en0", 3'd0, 1'b0, W_F0);
    cyc(1'b0, 1'b1); expect_now("reset_en1", 3'd0, 1'b0, W_F0);

    run_instr("add", 4'b0001, 1'b0, 1'b0, 5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD);
    run_instr("sub", 4'b0010, 1'b0, 1'b0, 5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD | ALU_SUB,
              ALU_OUT | A_LOAD | ALU_SUB);
    run_instr("lda", 4'b0000, 1'b0, 1'b0, 4, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, 14'h0);
    run_instr("sta", 4'b0111, 1'b0, 1'b0, 4, IR_OUT | MAR_LOAD, A_OUT | RAM_LOAD, 14'h0);
    run_instr("jmp", 4'b0011, 1'b0, 1'b0, 3, IR_OUT | PC_LOAD, 14'h0, 14'h0);
    run_instr("ldi", 4'b0110, 1'b0, 1'b0, 3, IR_OUT | A_LOAD, 14'h0, 14'h0);
    run_instr("out", 4'b1110, 1'b0, 1'b0, 3, A_OUT | OUT_LOAD, 14'h0, 14'h0);
    run_instr("nop", 4'b1010, 1'b1, 1'b1, 3, 14'h0, 14'h0, 14'h0);
    run_instr("jz_taken", 4'b0100, 1'b1, 1'b0, 3, W_JTAKEN, 14'h0, 14'h0);
    run_instr("jz_not", 4'b0100, 1'b0, 1'b1, 3, 14'h0, 14'h0, 14'h0);
    run_instr("jc_taken", 4'b0101, 1'b0, 1'b1, 3, W_JTAKEN, 14'h0, 14'h0);
    run_instr("jc_not", 4'b0101, 1'b1, 1'b0, 3, 14'h0, 14'h0, 14'h0);

    // LDA stalled in T3 by clk_en low.
    i_opcode = 4'b0000;
    cyc(1'b1, 1'b1); expect_now("stall_t1", 3'd1, 1'b0, W_F1);
    cyc(1'b1, 1'b1); expect_now("stall_t2", 3'd2, 1'b0, IR_OUT | MAR_LOAD);
    cyc(1'b1, 1'b1); expect_now("stall_t3", 3'd3, 1'b0, RAM_OUT | A_LOAD);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0); expect_now("stall_hold", 3'd3, 1'b0, RAM_OUT | A_LOAD);
    end
    cyc(1'b1, 1'b1); expect_now("stall_resume", 3'd0, 1'b0, W_F0);

    // HLT: sticky, frozen at T2 with a quiet control word whatever the opcode does.
    i_opcode = 4'b1111;
    cyc(1'b1, 1'b1); expect_now("hlt_t1", 3'd1, 1'b0, W_F1);
    cyc(1'b1, 1'b1); expect_now("hlt_t2", 3'd2, 1'b0, 14'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1); expect_now("halted", 3'd2, 1'b1, 14'h0);
      i_opcode = 4'b0001;
    end
    cyc(1'b0, 1'b1); expect_now("hlt_reset", 3'd0, 1'b0, W_F0);

    // Reset during T4 of ADD with clk_en low abandons the instruction.
    i_opcode = 4'b0001;
    cyc(1'b1, 1'b1); expect_now("abort_t1", 3'd1, 1'b0, W_F1);
    cyc(1'b1, 1'b1); expect_now("abort_t2", 3'd2, 1'b0, IR_OUT | MAR_LOAD);
    cyc(1'b1, 1'b1); expect_now("abort_t3", 3'd3, 1'b0, RAM_OUT | B_LOAD);
    cyc(1'b1, 1'b1); expect_now("abort_t4", 3'd4, 1'b0, ALU_OUT | A_LOAD);
    cyc(1'b0, 1'b0); expect_now("abort_rst", 3'd0, 1'b0, W_F0);
    cyc(1'b1, 1'b0); expect_now("abort_hold", 3'd0, 1'b0, W_F0);
    run_instr("add_after", 4'b0001, 1'b0, 1'b0, 5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD,
              ALU_OUT | A_LOAD);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end

endmodule
